seg_scan_ctrl: RTL and testbench

Time-multiplexing scan controller that shares one SevenSegment decoder across NUM_DIGITS common-anode digits of the board display. It holds a pending and a committed copy of the digit values. It drives the decoder's 4-bit `numin` one digit at a time and gates the decoder's active-low `segout` onto the pins. Each digit slot starts with a blanking interval to prevent ghosting. It sits between the processor's display register write port and the display pins.

---
 rtl/seg_scan_if.sv | 24 ++
 rtl/seg_scan_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Display-controller bus: processor write port, decoder hand-off and display pins.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [3:0]              numin;
  logic [6:0]              segout_in;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;

  modport master (
    output en, load, digits_in, dp_in, segout_in,
    input  numin, seg, dp, an
  );

  modport slave (
    input  en, load, digits_in, dp_in, segout_in,
    output numin, seg, dp, an
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode seven-segment digits sharing one decoder.
// Optional leading-zero suppression: define SEG_SCAN_LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 100000,
  parameter int BLANK_CYC  = 2500
) (
  input logic       clk,
  input logic       rst,
  seg_scan_if.slave bus
);

  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]      CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0]      IDX_ONE   = IDX_W'(1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t                  state_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [IDX_W-1:0]        idx_r;
  logic [3:0]              numin_r;
  logic [NUM_DIGITS-1:0]   an_r;
  logic                    dp_r;
  logic                    seg_on_r;
  logic [4*NUM_DIGITS-1:0] pend_digits_r;
  logic [NUM_DIGITS-1:0]   pend_dp_r;
  logic [4*NUM_DIGITS-1:0] cur_digits_r;
  logic [NUM_DIGITS-1:0]   cur_dp_r;

  logic                    cnt_last_s;
  logic                    idx_last_s;
  logic [IDX_W-1:0]        idx_nxt_s;
  logic [CNT_W-1:0]        cnt_inc_s;
  logic                    commit_s;
  logic [3:0]              numin_nxt_s;
  logic                    show_ok_s;

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0]   blank_mask_r;

  // Zero digits from the top down to the first nonzero one; digit 0 always shows.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] d);
    logic [NUM_DIGITS-1:0] m;
    logic                  run;
    m   = '0;
    run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (run && (d[4*i +: 4] == 4'h0)) begin
        m[i] = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
    return m;
  endfunction
`endif

  // Slot/digit bookkeeping and commit detection.
  always_comb begin
    cnt_last_s = (cnt_r == CNT_LAST);
    idx_last_s = (idx_r == IDX_LAST);
    cnt_inc_s  = cnt_r + CNT_ONE;
    if (idx_last_s) begin
      idx_nxt_s = '0;
    end else begin
      idx_nxt_s = idx_r + IDX_ONE;
    end
    commit_s = 1'b0;
    if (!bus.en) begin
      commit_s = 1'b0;
    end else if (state_r == ST_OFF) begin
      commit_s = 1'b1;
    end else if ((state_r == ST_SHOW) && cnt_last_s && idx_last_s) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
    // cur is being overwritten on a commit edge, so digit 0 comes straight from pend.
    if (commit_s) begin
      numin_nxt_s = pend_digits_r[3:0];
    end else begin
      numin_nxt_s = cur_digits_r[{idx_nxt_s, 2'b00} +: 4];
    end
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    show_ok_s = ~blank_mask_r[idx_r];
`else
    show_ok_s = 1'b1;
`endif
  end

  // Pending and committed digit storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_digits_r <= '0;
      pend_dp_r     <= '0;
      cur_digits_r  <= '0;
      cur_dp_r      <= '0;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
      blank_mask_r  <= '0;
`endif
    end else begin
      if (bus.load) begin
        pend_digits_r <= bus.digits_in;
        pend_dp_r     <= bus.dp_in;
      end
      if (commit_s) begin
        cur_digits_r <= pend_digits_r;
        cur_dp_r     <= pend_dp_r;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        blank_mask_r <= lz_mask(pend_digits_r);
`endif
      end
    end
  end

  // Scan FSM with registered pin drives.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_OFF;
      cnt_r    <= '0;
      idx_r    <= '0;
      numin_r  <= 4'h0;
      an_r     <= AN_OFF;
      dp_r     <= 1'b1;
      seg_on_r <= 1'b0;
    end else if (!bus.en) begin
      state_r  <= ST_OFF;
      cnt_r    <= '0;
      idx_r    <= '0;
      an_r     <= AN_OFF;
      dp_r     <= 1'b1;
      seg_on_r <= 1'b0;
    end else begin
      case (state_r)
        ST_OFF: begin
          state_r  <= ST_BLANK;
          cnt_r    <= '0;
          idx_r    <= '0;
          numin_r  <= numin_nxt_s;
          an_r     <= AN_OFF;
          dp_r     <= 1'b1;
          seg_on_r <= 1'b0;
        end
        ST_BLANK: begin
          cnt_r <= cnt_inc_s;
          if (cnt_inc_s == CNT_BLANK) begin
            state_r <= ST_SHOW;
            if (show_ok_s) begin
              an_r     <= ~(AN_ONE << idx_r);
              dp_r     <= ~cur_dp_r[idx_r];
              seg_on_r <= 1'b1;
            end
          end
        end
        ST_SHOW: begin
          if (cnt_last_s) begin
            state_r  <= ST_BLANK;
            cnt_r    <= '0;
            idx_r    <= idx_nxt_s;
            numin_r  <= numin_nxt_s;
            an_r     <= AN_OFF;
            dp_r     <= 1'b1;
            seg_on_r <= 1'b0;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        default: begin
          state_r  <= ST_OFF;
          cnt_r    <= '0;
          idx_r    <= '0;
          an_r     <= AN_OFF;
          dp_r     <= 1'b1;
          seg_on_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.numin = numin_r;
  assign bus.an    = an_r;
  assign bus.dp    = dp_r;
  assign bus.seg   = seg_on_r ? bus.segout_in : 7'h7F;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (NUM_DIGITS=4, DIV=8, BLANK_CYC=2) with a behavioural hex decoder.
module tb_seg_scan_ctrl;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  seg_scan_if #(.NUM_DIGITS(4)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS(4),
    .DIV       (8),
    .BLANK_CYC (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  localparam logic [3:0] MASK_ZERO = 4'b1110;
  localparam logic [3:0] MASK_0070 = 4'b1100;
`else
  localparam logic [3:0] MASK_ZERO = 4'b0000;
  localparam logic [3:0] MASK_0070 = 4'b0000;
`endif

  // Active-low {a,b,c,d,e,f,g} hex decoder standing in for the shared SevenSegment block.
  function automatic logic [6:0] dec7(input logic [3:0] n);
    case (n)
      4'h0: dec7 = 7'b0000001;
      4'h1: dec7 = 7'b1001111;
      4'h2: dec7 = 7'b0010010;
      4'h3: dec7 = 7'b0000110;
      4'h4: dec7 = 7'b1001100;
      4'h5: dec7 = 7'b0100100;
      4'h6: dec7 = 7'b0100000;
      4'h7: dec7 = 7'b0001111;
      4'h8: dec7 = 7'b0000000;
      4'h9: dec7 = 7'b0000100;
      4'hA: dec7 = 7'b0001000;
      4'hB: dec7 = 7'b1100000;
      4'hC: dec7 = 7'b0110001;
      4'hD: dec7 = 7'b1000010;
      4'hE: dec7 = 7'b0110000;
      default: dec7 = 7'b0111000;
    endcase
  endfunction

  assign bus.segout_in = dec7(bus.numin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks one 32-cycle frame from slot 0 cnt 0, optionally strobing load at (inj_slot, inj_cnt).
  task automatic check_frame(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] mask,
                             input int inj_slot, input int inj_cnt,
                             input logic [15:0] inj_d, input logic [3:0] inj_dp);
    logic [3:0] nib;
    logic [3:0] an_exp;
    logic       dp_exp;
    for (int i = 0; i < 4; i++) begin
      nib = d[i*4 +: 4];
      check_eq("blank_an", bus.an, 4'hF);
      check_eq("blank_numin", bus.numin, nib);
      check_eq("blank_seg", bus.seg, 7'h7F);
      check_eq("blank_dp", bus.dp, 1'b1);
      tick();
      tick();
      if (mask[i]) begin
        check_eq("supp_an", bus.an, 4'hF);
        check_eq("supp_seg", bus.seg, 7'h7F);
        check_eq("supp_dp", bus.dp, 1'b1);
      end else begin
        an_exp = 4'b1111;
        an_exp[i] = 1'b0;
        dp_exp = ~dpv[i];
        check_eq("show_an", bus.an, an_exp);
        check_eq("show_numin", bus.numin, nib);
        check_eq("show_seg", bus.seg, dec7(nib));
        check_eq("show_dp", bus.dp, dp_exp);
      end
      if (i == inj_slot) begin
        repeat (inj_cnt - 2) tick();
        bus.load      = 1'b1;
        bus.digits_in = inj_d;
        bus.dp_in     = inj_dp;
        tick();
        bus.load = 1'b0;
        repeat (7 - inj_cnt) tick();
      end else begin
        repeat (6) tick();
      end
    end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b1;
    bus.en        = 1'b1;
    bus.load      = 1'b1;
    bus.digits_in = 16'h1234;
    bus.dp_in     = 4'hF;

    // Reset dominates en and load.
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("rst_an", bus.an, 4'hF);
      check_eq("rst_seg", bus.seg, 7'h7F);
      check_eq("rst_dp", bus.dp, 1'b1);
      check_eq("rst_numin", bus.numin, 4'h0);
    end
    rst      = 1'b0;
    bus.load = 1'b0;
    tick();
    tick();
    check_eq("start_an_blank", bus.an, 4'hF);
    tick();
    check_eq("start_an", bus.an, 4'b1110);
    check_eq("start_numin", bus.numin, 4'h0);
    check_eq("start_seg", bus.seg, dec7(4'h0));

    // Load 1234 while off, then scan.
    bus.en = 1'b0;
    tick();
    check_eq("off_an", bus.an, 4'hF);
    check_eq("off_seg", bus.seg, 7'h7F);
    bus.load      = 1'b1;
    bus.digits_in = 16'h1234;
    bus.dp_in     = 4'b0100;
    tick();
    bus.load = 1'b0;
    bus.en   = 1'b1;
    tick();
    check_frame(16'h1234, 4'b0100, 4'b0000, -1, 0, 16'h0, 4'h0);
    check_frame(16'h1234, 4'b0100, 4'b0000, 2, 4, 16'h5678, 4'b0000);
    check_frame(16'h5678, 4'b0000, 4'b0000, 3, 7, 16'hABCD, 4'b0001);
    check_frame(16'h5678, 4'b0000, 4'b0000, -1, 0, 16'h0, 4'h0);
    check_frame(16'hABCD, 4'b0001, 4'b0000, -1, 0, 16'h0, 4'h0);

    // en drop and re-raise during SHOW.
    repeat (3) tick();
    bus.en = 1'b0;
    tick();
    check_eq("endrop_an", bus.an, 4'hF);
    check_eq("endrop_dp", bus.dp, 1'b1);
    check_eq("endrop_seg", bus.seg, 7'h7F);
    bus.en = 1'b1;
    tick();
    check_eq("reen_an", bus.an, 4'hF);
    check_eq("reen_numin", bus.numin, 4'hD);
    tick();
    tick();
    check_eq("reen_show_an", bus.an, 4'b1110);
    check_eq("reen_show_numin", bus.numin, 4'hD);
    check_eq("reen_show_dp", bus.dp, 1'b0);

    // Reset in SHOW clears pend and cur.
    tick();
    rst = 1'b1;
    tick();
    check_eq("midrst_an", bus.an, 4'hF);
    check_eq("midrst_numin", bus.numin, 4'h0);
    check_eq("midrst_seg", bus.seg, 7'h7F);
    check_eq("midrst_dp", bus.dp, 1'b1);
    rst = 1'b0;
    tick();
    check_frame(16'h0000, 4'b0000, MASK_ZERO, -1, 0, 16'h0, 4'h0);

    // Leading zeros.
    bus.en = 1'b0;
    tick();
    bus.load      = 1'b1;
    bus.digits_in = 16'h0070;
    bus.dp_in     = 4'b0000;
    tick();
    bus.load = 1'b0;
    bus.en   = 1'b1;
    tick();
    check_frame(16'h0070, 4'b0000, MASK_0070, -1, 0, 16'h0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
